// File: rtl/amp_cal_pkg.sv
// Shared definitions for the amplifier offset-calibration sequencer.
//   cal_state_t : sequencer state encoding
//   trim_mid()  : mid-scale trim code (1 << (trim_w-1)) for a given code width
//   ch_idx_w()  : width of a channel index for a given channel count (min 1)
package amp_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_DECIDE,
    ST_STORE,
    ST_FINISH
  } cal_state_t;

  function automatic int unsigned trim_mid(input int unsigned trim_w);
    return 32'd1 << (trim_w - 32'd1);
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 32'd1) ? 32'($clog2(num_ch)) : 32'd1;
  endfunction

endpackage

// File: rtl/amp_trim_cal_if.sv
// Host/analog-side bundle of the calibration sequencer.
//   master : host + analog tile (drives start/abort/config/cmp_in/writes)
//   slave  : sequencer (drives trim_flat, cal_short, busy, done)
//   start         one-cycle calibration request
//   abort         stop the run immediately
//   cal_mask      channels to calibrate
//   settle_cycles settle wait per trial (0 treated as 1)
//   cmp_in        async comparator, 1 = code too high
//   wr_en/wr_ch/wr_data host trim write
//   trim_flat     trim codes, channel k at [k*TRIM_W +: TRIM_W]
//   cal_short     one-hot input short for the channel under calibration
//   busy, done    run in progress / completion pulse
interface amp_trim_cal_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TRIM_W   = 5,
  parameter int unsigned SETTLE_W = 8
);
  localparam int unsigned CH_IDX_W = amp_cal_pkg::ch_idx_w(NUM_CH);

  logic                       start;
  logic                       abort;
  logic [NUM_CH-1:0]          cal_mask;
  logic [SETTLE_W-1:0]        settle_cycles;
  logic                       cmp_in;
  logic                       wr_en;
  logic [CH_IDX_W-1:0]        wr_ch;
  logic [TRIM_W-1:0]          wr_data;
  logic [NUM_CH*TRIM_W-1:0]   trim_flat;
  logic [NUM_CH-1:0]          cal_short;
  logic                       busy;
  logic                       done;

  modport master (
    output start, abort, cal_mask, settle_cycles, cmp_in, wr_en, wr_ch, wr_data,
    input  trim_flat, cal_short, busy, done
  );

  modport slave (
    input  start, abort, cal_mask, settle_cycles, cmp_in, wr_en, wr_ch, wr_data,
    output trim_flat, cal_short, busy, done
  );

endinterface

// File: rtl/amp_cal_sync2.sv
// Two-flop synchroniser for the asynchronous comparator output.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d_i        : asynchronous input
//   q_o        : synchronised output (2-cycle latency)
module amp_cal_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/amp_trim_cal.sv
// Offset-calibration sequencer for a bank of NUM_CH differential amplifiers.
// For each masked-in channel it shorts the amp inputs and runs a successive-
// approximation search on that channel's trim code using the comparator,
// then stores the result. The host can write trim codes while idle.
//   clk, rst_n : clock, async active-low reset
//   bus        : amp_trim_cal_if slave (start/abort/config, comparator,
//                host write, trim codes, shorts, busy/done)
module amp_trim_cal
  import amp_cal_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TRIM_W   = 5,
  parameter int unsigned SETTLE_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  amp_trim_cal_if.slave bus
);

  localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int unsigned BIT_W    = $clog2(TRIM_W);
  localparam int unsigned CNT_W    = SETTLE_W + 1;
  localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(trim_mid(TRIM_W));

  cal_state_t            state_q,  state_d;
  logic [CH_IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [TRIM_W-1:0]     trial_q,  trial_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [NUM_CH-1:0]     mask_q,   mask_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [TRIM_W-1:0]     trim_q [NUM_CH];

  logic                  cmp_sync;
  logic                  store_en;
  logic [SETTLE_W-1:0]   settle_eff;
  logic [CNT_W-1:0]      cnt_load;
  logic [NUM_CH-1:0]     search_mask;
  int unsigned           search_from;
  logic                  nxt_found;
  logic [CH_IDX_W-1:0]   nxt_ch;
  logic                  busy_w;
  logic [NUM_CH-1:0]     short_w;
  logic [NUM_CH*TRIM_W-1:0] flat_w;

  amp_cal_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.cmp_in),
    .q_o   (cmp_sync)
  );

  // SETTLE lasts S+2 cycles (S = max(settle,1)); counter runs S+1 down to 0.
  always_comb begin
    settle_eff = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
    cnt_load   = {1'b0, settle_eff} + CNT_W'(1);
  end

  // Lowest masked-in channel at or above the search start. From IDLE the
  // live mask is searched from 0; from STORE the latched mask from ch_idx+1.
  always_comb begin
    search_mask = (state_q == ST_IDLE) ? bus.cal_mask : mask_q;
    search_from = (state_q == ST_STORE) ? (32'(ch_idx_q) + 32'd1) : 32'd0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!nxt_found && search_mask[k] && (k >= search_from)) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_IDX_W'(k);
      end
    end
  end

  // Channel index and trial are loaded on entry to SELECT so the live
  // trial is already mid-scale while the channel is selected.
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    trial_d  = trial_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    store_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d   = bus.cal_mask;
          settle_d = bus.settle_cycles;
          if (nxt_found) begin
            state_d  = ST_SELECT;
            ch_idx_d = nxt_ch;
            trial_d  = TRIM_MID;
            bit_d    = BIT_W'(TRIM_W - 1);
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_SELECT: begin
        state_d = ST_SETTLE;
        cnt_d   = cnt_load;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DECIDE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DECIDE: begin
        if (cmp_sync) trial_d[bit_q] = 1'b0;
        if (bit_q != '0) begin
          trial_d[bit_q - BIT_W'(1)] = 1'b1;
          bit_d   = bit_q - BIT_W'(1);
          cnt_d   = cnt_load;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        if (nxt_found) begin
          state_d  = ST_SELECT;
          ch_idx_d = nxt_ch;
          trial_d  = TRIM_MID;
          bit_d    = BIT_W'(TRIM_W - 1);
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      store_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_idx_q <= '0;
      trial_q  <= TRIM_MID;
      bit_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      trial_q  <= trial_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) trim_q[k] <= TRIM_MID;
    end else if (store_en) begin
      trim_q[ch_idx_q] <= trial_q;
    end else if ((state_q == ST_IDLE) && bus.wr_en && (32'(bus.wr_ch) < NUM_CH)) begin
      trim_q[bus.wr_ch] <= bus.wr_data;
    end
  end

  always_comb begin
    busy_w  = state_q inside {ST_SELECT, ST_SETTLE, ST_DECIDE, ST_STORE};
    short_w = '0;
    if (state_q inside {ST_SELECT, ST_SETTLE, ST_DECIDE}) short_w[ch_idx_q] = 1'b1;
    flat_w = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      flat_w[k*TRIM_W +: TRIM_W] = (busy_w && (ch_idx_q == CH_IDX_W'(k))) ? trial_q : trim_q[k];
    end
  end

  assign bus.trim_flat = flat_w;
  assign bus.cal_short = short_w;
  assign bus.busy      = busy_w;
  assign bus.done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_amp_trim_cal.sv
// Self-checking bench for amp_trim_cal (NUM_CH=4, TRIM_W=5, SETTLE_W=8).
// The comparator is modelled as (live trial of shorted channel > target).
module tb_amp_trim_cal;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned TRIM_W   = 5;
  localparam int unsigned SETTLE_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amp_trim_cal_if #(.NUM_CH(NUM_CH), .TRIM_W(TRIM_W), .SETTLE_W(SETTLE_W)) bus ();

  amp_trim_cal #(.NUM_CH(NUM_CH), .TRIM_W(TRIM_W), .SETTLE_W(SETTLE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] target   [4];
  logic [4:0] exp_trim [4];

  // Analog model: shorted amp output is positive when the code exceeds target.
  logic cmp_model;
  always_comb begin
    cmp_model = 1'b0;
    for (int k = 0; k < 4; k++)
      if (bus.cal_short[k]) cmp_model = (bus.trim_flat[k*5 +: 5] > target[k]);
  end
  assign bus.cmp_in = cmp_model;

  // Activity monitor sampled on the falling edge.
  int         mon_busy  = 0;
  int         mon_done  = 0;
  int         mon_multi = 0;
  logic [3:0] mon_prev  = '0;
  logic [3:0] mon_seq [$];
  always @(negedge clk) begin
    if (bus.busy === 1'b1) mon_busy <= mon_busy + 1;
    if (bus.done === 1'b1) mon_done <= mon_done + 1;
    if ($countones(bus.cal_short) > 1) mon_multi <= mon_multi + 1;
    if (bus.cal_short != 4'd0 && bus.cal_short != mon_prev) mon_seq.push_back(bus.cal_short);
    mon_prev <= bus.cal_short;
  end

  // Largest code the comparator calls "not too high".
  function automatic logic [4:0] ref_code(input logic [4:0] tgt);
    int best;
    best = 0;
    for (int c = 0; c < 32; c++) if (!(c > int'(tgt))) best = c;
    return 5'(best);
  endfunction

  function automatic int ref_busy(input logic [3:0] mask, input int s);
    int se;
    se = (s == 0) ? 1 : s;
    return $countones(mask) * (2 + 5 * (se + 3));
  endfunction

  // Caller is at a falling edge. Issues start, optionally disturbs the run,
  // and waits (bounded) for done.
  task automatic do_run(input logic [3:0] mask, input logic [7:0] settle, input bit scramble,
                        input bit mid_wr, input int wr_at, input logic [1:0] wch,
                        input logic [4:0] wdat, output bit timed_out);
    int cyc;
    bus.cal_mask      = mask;
    bus.settle_cycles = settle;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (scramble) begin
      bus.cal_mask      = 4'($urandom);
      bus.settle_cycles = 8'($urandom_range(100, 255));
    end
    timed_out = 1'b1;
    cyc = 0;
    while (cyc < 1500) begin
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      bus.start = scramble && (cyc == 5);
      if (mid_wr && cyc == wr_at) begin
        bus.wr_en = 1'b1; bus.wr_ch = wch; bus.wr_data = wdat;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (timed_out) begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [19:0] all_mid;
    all_mid = {4{5'b10000}};
    @(negedge clk);
    n_tests++; if (bus.trim_flat !== all_mid) begin n_fail++; $display("FAIL reset_trim: got %h expected %h", bus.trim_flat, all_mid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.cal_short !== 4'd0) begin n_fail++; $display("FAIL reset_short: got %b expected 0000", bus.cal_short); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    for (int k = 0; k < 4; k++) target[k] = 5'($urandom_range(0, 31));
    bus.cal_mask = 4'hF; bus.settle_cycles = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.trim_flat !== all_mid) begin n_fail++; $display("FAIL async_reset_trim: got %h expected %h", bus.trim_flat, all_mid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.cal_short !== 4'd0) begin n_fail++; $display("FAIL async_reset_short: got %b expected 0000", bus.cal_short); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_trim[k] = 5'b10000;
  endtask

  task automatic test_full_run();
    int b0, d0, s0, m0;
    bit to;
    @(negedge clk);
    target[0] = 5'd19; target[1] = 5'd0; target[2] = 5'd31; target[3] = 5'd7;
    b0 = mon_busy; d0 = mon_done; s0 = mon_seq.size(); m0 = mon_multi;
    // host write to channel 0 mid-run must be ignored
    do_run(4'hF, 8'd3, 1'b0, 1'b1, 50, 2'd0, 5'd2, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL full_timeout: done not seen within budget"); end
    for (int k = 0; k < 4; k++) exp_trim[k] = ref_code(target[k]);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL full_trim%0d: got %0d expected %0d", k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
    end
    n_tests++; if (mon_busy - b0 != ref_busy(4'hF, 3)) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected %0d", mon_busy - b0, ref_busy(4'hF, 3)); end
    n_tests++; if (mon_done - d0 != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", mon_done - d0); end
    n_tests++; if (mon_multi != m0) begin n_fail++; $display("FAIL full_short_onehot: got %0d multi-hot samples expected 0", mon_multi - m0); end
    n_tests++;
    if (mon_seq.size() - s0 != 4) begin
      n_fail++; $display("FAIL full_short_seq_len: got %0d expected 4", mon_seq.size() - s0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (mon_seq[s0+k] !== 4'(1 << k)) begin n_fail++; $display("FAIL full_short_seq%0d: got %b expected %b", k, mon_seq[s0+k], 4'(1 << k)); end
      end
    end
  endtask

  task automatic test_mask();
    int b0, d0, s0;
    bit to;
    @(negedge clk);
    target[0] = 5'($urandom_range(0, 31)); target[2] = 5'($urandom_range(0, 31));
    bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_data = 5'd9;
    @(negedge clk);
    bus.wr_ch = 2'd3; bus.wr_data = 5'd22;
    exp_trim[1] = 5'd9; exp_trim[3] = 5'd22;
    b0 = mon_busy; d0 = mon_done; s0 = mon_seq.size();
    // channel 3 write coincides with start
    do_run(4'b0101, 8'd3, 1'b0, 1'b0, 0, 2'd0, 5'd0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL mask_timeout: done not seen within budget"); end
    exp_trim[0] = ref_code(target[0]); exp_trim[2] = ref_code(target[2]);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL mask_trim%0d: got %0d expected %0d", k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
    end
    n_tests++; if (mon_busy - b0 != ref_busy(4'b0101, 3)) begin n_fail++; $display("FAIL mask_busy_cycles: got %0d expected %0d", mon_busy - b0, ref_busy(4'b0101, 3)); end
    n_tests++; if (mon_done - d0 != 1) begin n_fail++; $display("FAIL mask_done_count: got %0d expected 1", mon_done - d0); end
    n_tests++;
    if (mon_seq.size() - s0 != 2) begin
      n_fail++; $display("FAIL mask_short_seq_len: got %0d expected 2", mon_seq.size() - s0);
    end else begin
      n_tests++;
      if (mon_seq[s0] !== 4'b0001 || mon_seq[s0+1] !== 4'b0100) begin n_fail++; $display("FAIL mask_short_seq: got %b,%b expected 0001,0100", mon_seq[s0], mon_seq[s0+1]); end
    end
  endtask

  task automatic test_empty_mask();
    int b0;
    @(negedge clk);
    b0 = mon_busy;
    bus.cal_mask = 4'd0; bus.settle_cycles = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL empty_done_pulse: got %b expected 1", bus.done); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL empty_done_width: got %b expected 0", bus.done); end
    repeat (2) @(negedge clk);
    n_tests++; if (mon_busy != b0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles expected 0", mon_busy - b0); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL empty_trim%0d: got %0d expected %0d", k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
    end
  endtask

  task automatic test_abort();
    int d0, cyc, part, cand;
    @(negedge clk);
    for (int k = 0; k < 4; k++) target[k] = 5'($urandom_range(0, 31));
    bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_data = 5'd13;
    @(negedge clk);
    bus.wr_ch = 2'd3; bus.wr_data = 5'd27;
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_trim[2] = 5'd13; exp_trim[3] = 5'd27;
    d0 = mon_done;
    bus.cal_mask = 4'hF; bus.settle_cycles = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.cal_short !== 4'b0100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (cyc >= 400) begin n_fail++; $display("FAIL abort_wait_ch2: got no channel-2 short expected within 400 cycles"); end
    // SELECT + two completed bits (6 cycles each) + 2 cycles into the third bit
    repeat (15) @(negedge clk);
    part = 0;
    for (int b = 4; b >= 3; b--) begin
      cand = part | (1 << b);
      if (!(cand > int'(target[2]))) part = cand;
    end
    part = part | 4;
    n_tests++; if (bus.trim_flat[10 +: 5] !== 5'(part)) begin n_fail++; $display("FAIL abort_live_trial: got %0d expected %0d", bus.trim_flat[10 +: 5], part); end
    n_tests++; if (bus.trim_flat[15 +: 5] !== 5'd27) begin n_fail++; $display("FAIL abort_idle_ch3_view: got %0d expected 27", bus.trim_flat[15 +: 5]); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.cal_short !== 4'd0) begin n_fail++; $display("FAIL abort_short: got %b expected 0000", bus.cal_short); end
    repeat (4) @(negedge clk);
    n_tests++; if (mon_done != d0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", mon_done - d0); end
    exp_trim[0] = ref_code(target[0]); exp_trim[1] = ref_code(target[1]);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL abort_trim%0d: got %0d expected %0d", k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
    end
  endtask

  task automatic test_settle_zero();
    int b0;
    bit to;
    @(negedge clk);
    for (int k = 0; k < 4; k++) target[k] = 5'($urandom_range(0, 31));
    for (int pass = 0; pass < 2; pass++) begin
      b0 = mon_busy;
      do_run(4'hF, 8'(pass), 1'b0, 1'b0, 0, 2'd0, 5'd0, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL settle%0d_timeout: done not seen within budget", pass); end
      n_tests++; if (mon_busy - b0 != 88) begin n_fail++; $display("FAIL settle%0d_busy_cycles: got %0d expected 88", pass, mon_busy - b0); end
      for (int k = 0; k < 4; k++) begin
        exp_trim[k] = ref_code(target[k]);
        n_tests++;
        if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL settle%0d_trim%0d: got %0d expected %0d", pass, k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, s;
    logic [3:0] mask;
    bit to;
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) target[k] = 5'($urandom_range(0, 31));
      mask = 4'($urandom_range(1, 15));
      s    = $urandom_range(0, 4);
      b0 = mon_busy; d0 = mon_done;
      // inputs scrambled and a second start pulsed after the run begins
      do_run(mask, 8'(s), 1'b1, 1'b0, 0, 2'd0, 5'd0, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL b2b%0d_timeout: done not seen within budget", it); end
      n_tests++; if (mon_busy - b0 != ref_busy(mask, s)) begin n_fail++; $display("FAIL b2b%0d_busy_cycles: got %0d expected %0d", it, mon_busy - b0, ref_busy(mask, s)); end
      n_tests++; if (mon_done - d0 != 1) begin n_fail++; $display("FAIL b2b%0d_done_count: got %0d expected 1", it, mon_done - d0); end
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) exp_trim[k] = ref_code(target[k]);
        n_tests++;
        if (bus.trim_flat[k*5 +: 5] !== exp_trim[k]) begin n_fail++; $display("FAIL b2b%0d_trim%0d: got %0d expected %0d", it, k, bus.trim_flat[k*5 +: 5], exp_trim[k]); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.cal_mask = '0; bus.settle_cycles = '0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    for (int k = 0; k < 4; k++) begin target[k] = '0; exp_trim[k] = 5'b10000; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_run();
    test_mask();
    test_empty_mask();
    test_abort();
    test_settle_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
